// File: rtl/icache_ctrl.sv
// Direct-mapped L1 instruction cache controller: combinational hits, single-line
// refill over a req/gnt + beat port, and whole-cache invalidate for fence.i.
module icache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_address,
    input  logic        Icache_en,
    input  logic        icache_flush,
    output logic [31:0] instr,
    output logic        Istall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int OFF  = $clog2(WORDS);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - OFF - IDX;
    localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS - 1);
    localparam logic [31:0]    NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LINES-1:0]   r_valid;
    logic [OFF-1:0]     r_beat;
    logic               r_flush_pend;

    logic [TAGW-1:0]    r_tag  [LINES];
    logic [31:0]        r_data [LINES][WORDS];
    logic [31:0]        r_buf  [WORDS];
    logic [31:0]        r_resp;
    logic [TAGW-1:0]    r_tag_l;
    logic [IDX-1:0]     r_idx_l;
    logic [OFF-1:0]     r_off_l;

    logic [OFF-1:0]     w_off;
    logic [IDX-1:0]     w_idx;
    logic [TAGW-1:0]    w_tag;
    logic               w_hit;
    logic               w_miss;
    logic               w_last;
    logic               w_unused;

    assign w_off    = PC_address[OFF+1:2];
    assign w_idx    = PC_address[OFF+IDX+1:OFF+2];
    assign w_tag    = PC_address[31:OFF+IDX+2];
    assign w_unused = &{1'b0, PC_address[1:0]};

    // A flush in the request cycle forces a miss even if the tag matches.
    assign w_hit  = Icache_en && !icache_flush && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss = Icache_en && !w_hit;
    assign w_last = mem_rvalid && (r_beat == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (icache_flush)
                        r_valid <= '0;
                end
                MISS_REQ: begin
                    if (icache_flush)
                        r_flush_pend <= 1'b1;
                end
                REFILL: begin
                    if (icache_flush)
                        r_flush_pend <= 1'b1;
                    if (mem_rvalid)
                        r_beat <= r_beat + 1'b1;
                    if (w_last)
                        r_valid[r_idx_l] <= 1'b1;
                end
                RESP: begin
                    // Entering IDLE: honour any flush seen during the miss, including this cycle's.
                    if (r_flush_pend || icache_flush) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_miss) begin
            r_tag_l <= w_tag;
            r_idx_l <= w_idx;
            r_off_l <= w_off;
        end
        if (r_state == REFILL && mem_rvalid) begin
            r_buf[r_beat] <= mem_rdata;
            if (r_beat == r_off_l)
                r_resp <= mem_rdata;
            // Whole line lands at once so a partial refill is never visible.
            if (r_beat == LAST_BEAT) begin
                r_tag[r_idx_l] <= r_tag_l;
                for (int w = 0; w < WORDS; w++)
                    r_data[r_idx_l][w] <= (w == WORDS - 1) ? mem_rdata : r_buf[w];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        instr       = NOP;
        Istall      = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    instr = r_data[w_idx][w_off];
                end else if (w_miss) begin
                    Istall      = 1'b1;
                    w_state_nxt = MISS_REQ;
                end
            end
            MISS_REQ: begin
                Istall   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {r_tag_l, r_idx_l, {(OFF + 2){1'b0}}};
                if (mem_gnt)
                    w_state_nxt = REFILL;
            end
            REFILL: begin
                Istall = 1'b1;
                if (w_last)
                    w_state_nxt = RESP;
            end
            RESP: begin
                instr       = r_resp;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (rst) begin
            instr    = NOP;
            Istall   = 1'b0;
            mem_req  = 1'b0;
            mem_addr = '0;
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized bench for icache_ctrl: the bench plays instruction memory and keeps
// an array model of line valid/tag/data derived from the address-split rules.
module tb_icache_ctrl;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_address;
    logic        Icache_en;
    logic        icache_flush;
    logic [31:0] instr;
    logic        Istall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    logic [31:0] mdata  [LINES][WORDS];

    icache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .PC_address(PC_address), .Icache_en(Icache_en), .icache_flush(icache_flush),
        .instr(instr), .Istall(Istall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic model_clear;
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    // One fetch: hit or full miss handled as memory. Returns Istall seen in the request cycle.
    task automatic do_access(input logic [31:0] addr, input int gnt_delay, input bit gaps,
                             input bit flush_req, input int flush_beat,
                             input bit use_base, input logic [31:0] base, output logic stalled);
        int          idx, off;
        logic [31:0] tag, al;
        logic [31:0] line [WORDS];
        bit          pend;
        idx = int'((addr / 16) % LINES);
        off = int'((addr / 4) % WORDS);
        tag = addr / (16 * LINES);
        al  = addr - (addr % 16);
        PC_address   = addr;
        Icache_en    = 1'b1;
        icache_flush = flush_req;
        if (flush_req) model_clear();
        settle();
        stalled = Istall;
        if (mvalid[idx] && mtag[idx] == tag) begin
            checks++;
            if (Istall !== 1'b0 || instr !== mdata[idx][off] || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL hit addr=%h: got instr=%h stall=%b req=%b, want instr=%h stall=0 req=0",
                         addr, instr, Istall, mem_req, mdata[idx][off]);
            end
            next_cycle();
            Icache_en = 1'b0;
            return;
        end
        checks++;
        if (Istall !== 1'b1) begin
            failures++;
            $display("FAIL miss_stall addr=%h: got Istall=%b want 1", addr, Istall);
        end
        next_cycle();
        icache_flush = 1'b0;
        PC_address   = $urandom;
        Icache_en    = 1'($urandom_range(0, 1));
        for (int c = 0; c <= gnt_delay; c++) begin
            mem_gnt    = (c == gnt_delay);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 | c;
            settle();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== al || Istall !== 1'b1) begin
                failures++;
                $display("FAIL miss_req cyc=%0d: got req=%b addr=%h stall=%b, want req=1 addr=%h stall=1",
                         c, mem_req, mem_addr, Istall, al);
            end
            next_cycle();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        pend       = 1'b0;
        for (int b = 0; b < WORDS; b++) begin
            line[b]      = use_base ? base + b : $urandom;
            mem_rvalid   = 1'b1;
            mem_rdata    = line[b];
            icache_flush = (b == flush_beat);
            if (b == flush_beat) pend = 1'b1;
            settle();
            checks++;
            if (Istall !== 1'b1 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL refill beat=%0d: got stall=%b req=%b, want stall=1 req=0", b, Istall, mem_req);
            end
            next_cycle();
            icache_flush = 1'b0;
            if (gaps && b < WORDS - 1) begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                settle();
                checks++;
                if (Istall !== 1'b1) begin
                    failures++;
                    $display("FAIL refill_gap beat=%0d: got stall=%b want 1", b, Istall);
                end
                next_cycle();
            end
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        settle();
        checks++;
        if (Istall !== 1'b0 || instr !== line[off] || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL resp addr=%h: got instr=%h stall=%b req=%b, want instr=%h stall=0 req=0",
                     addr, instr, Istall, mem_req, line[off]);
        end
        mvalid[idx] = 1'b1;
        mtag[idx]   = tag;
        for (int w = 0; w < WORDS; w++) mdata[idx][w] = line[w];
        if (pend) model_clear();
        next_cycle();
        Icache_en = 1'b0;
        settle();
        checks++;
        if (instr !== NOP || Istall !== 1'b0) begin
            failures++;
            $display("FAIL resp_one_cycle: got instr=%h stall=%b, want instr=%h stall=0", instr, Istall, NOP);
        end
        next_cycle();
    endtask

    task automatic test_reset;
        rst = 1'b1; PC_address = '0; Icache_en = 1'b0; icache_flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_clear();
        repeat (2) next_cycle();
        settle();
        checks++;
        if (instr !== NOP || Istall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got instr=%h stall=%b req=%b addr=%h, want %h 0 0 0",
                     instr, Istall, mem_req, mem_addr, NOP);
        end
        Icache_en = 1'b1; PC_address = 32'h1000_0004;
        settle();
        checks++;
        if (Istall !== 1'b0 || instr !== NOP) begin
            failures++;
            $display("FAIL reset_en_held: got stall=%b instr=%h, want 0 %h", Istall, instr, NOP);
        end
        Icache_en = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_cold_miss;
        logic st;
        do_access(32'h1000_0004, 0, 1'b0, 1'b0, -1, 1'b1, 32'hA0, st);
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL cold_miss_stall: got %b want 1", st); end
    endtask

    task automatic test_hit;
        PC_address = 32'h1000_000C; Icache_en = 1'b1;
        settle();
        checks++;
        if (instr !== 32'hA3 || Istall !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL hit_after_fill: got instr=%h stall=%b req=%b, want 000000a3 0 0", instr, Istall, mem_req);
        end
        next_cycle();
        Icache_en = 1'b0;
    endtask

    task automatic test_conflict;
        logic st;
        do_access(32'h1000_0100, 0, 1'b0, 1'b0, -1, 1'b1, 32'hB0, st);
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL conflict_new_tag: got stall=%b want 1", st); end
        do_access(32'h1000_0000, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, st);
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL conflict_evicted: got stall=%b want 1", st); end
    endtask

    task automatic test_gaps;
        logic st;
        do_access(32'h1000_2034, 3, 1'b1, 1'b0, -1, 1'b0, 32'h0, st);
        for (int w = 0; w < WORDS; w++) begin
            do_access(32'h1000_2030 + 32'(w * 4), 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, st);
            checks++;
            if (st !== 1'b0) begin failures++; $display("FAIL gaps_word%0d_hit: got stall=%b want 0", w, st); end
        end
    endtask

    task automatic test_flush_idle;
        logic st;
        do_access(32'h1000_0008, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, st);
        checks++;
        if (st !== 1'b0) begin failures++; $display("FAIL flush_pre_hit: got stall=%b want 0", st); end
        icache_flush = 1'b1; Icache_en = 1'b0;
        settle();
        checks++;
        if (Istall !== 1'b0 || instr !== NOP) begin
            failures++;
            $display("FAIL flush_idle_out: got stall=%b instr=%h, want 0 %h", Istall, instr, NOP);
        end
        model_clear();
        next_cycle();
        icache_flush = 1'b0;
        do_access(32'h1000_0008, 1, 1'b0, 1'b0, -1, 1'b0, 32'h0, st);
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL flush_idle_remiss: got stall=%b want 1", st); end
        do_access(32'h1000_0008, 0, 1'b0, 1'b1, -1, 1'b0, 32'h0, st);
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL flush_with_req: got stall=%b want 1", st); end
    endtask

    task automatic test_flush_refill;
        logic st;
        do_access(32'h1000_3004, 0, 1'b0, 1'b0, 2, 1'b0, 32'h0, st);
        do_access(32'h1000_3004, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, st);
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL flush_refill_remiss: got stall=%b want 1", st); end
    endtask

    task automatic test_reset_refill;
        logic st;
        PC_address = 32'h1000_0000; Icache_en = 1'b1;
        settle();
        checks++;
        if (Istall !== 1'b1) begin failures++; $display("FAIL rstref_miss: got stall=%b want 1", Istall); end
        next_cycle();
        mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hC0 + b;
            next_cycle();
        end
        rst = 1'b1; mem_rdata = 32'hC2;
        settle();
        checks++;
        if (mem_req !== 1'b0 || Istall !== 1'b0 || instr !== NOP || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rstref_during: got req=%b stall=%b instr=%h addr=%h, want 0 0 %h 0",
                     mem_req, Istall, instr, mem_addr, NOP);
        end
        next_cycle();
        rst = 1'b0; Icache_en = 1'b0; mem_rdata = 32'hC3;
        model_clear();
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (Istall !== 1'b0 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL rstref_late_beat%0d: got stall=%b req=%b, want 0 0", c, Istall, mem_req);
            end
            next_cycle();
        end
        mem_rvalid = 1'b0;
        do_access(32'h1000_0000, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, st);
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL rstref_remiss: got stall=%b want 1", st); end
    endtask

    task automatic test_random;
        logic        st;
        logic [31:0] a;
        int          fb;
        for (int n = 0; n < 80; n++) begin
            a = 32'h2000_0000 + 32'($urandom_range(0, 2) * 256) + 32'($urandom_range(0, 15) * 16)
              + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_access(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 11) == 0), fb, 1'b0, 32'h0, st);
            if ($urandom_range(0, 3) == 0) next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_gaps();
        test_flush_idle();
        test_flush_refill();
        test_reset_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
